axis_bcd_scheduler: RTL and testbench

AXIS_BCD_SCHEDULER -- requirements
Module: axis_bcd_scheduler

---
 rtl/axis_bcd_pkg.sv | 60 ++++++
 rtl/axis_bcd_scheduler_conv.sv | 52 +++++
 rtl/axis_bcd_scheduler.sv | 174 +++++++++++++++++
 tb/tb_axis_bcd_scheduler.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_bcd_pkg.sv
// Shared types and constants for the axis BCD scheduler.
// Build option: define AXIS_BCD_SCALE_EN to convert magnitudes scaled by 4
// (mg units, 12-bit) instead of the raw 10-bit magnitude.
package axis_bcd_pkg;

  localparam int MAG_W    = 10;
  localparam int SCALED_W = 12;
  localparam int DIGITS   = 4;
  localparam int BCD_W    = DIGITS * 4;

`ifdef AXIS_BCD_SCALE_EN
  localparam int CONV_W = SCALED_W;
`else
  localparam int CONV_W = MAG_W;
`endif

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    STORE,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    AXIS_X,
    AXIS_Y,
    AXIS_Z
  } axis_t;

  typedef logic [3:0] bcd_digit_t;

  // Adds 3 to every digit that is 5 or more, ahead of the next left shift.
  function automatic logic [BCD_W-1:0] bcd_add3(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    bcd_digit_t       d;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      d = r[i*4 +: 4];
      if (d >= 4'd5) begin
        d = d + 4'd3;
      end
      r[i*4 +: 4] = d;
    end
    return r;
  endfunction

  // Sign-magnitude split of a 10-bit two's complement word; -512 maps to 512,
  // which still fits the unsigned 10-bit result.
  function automatic logic [CONV_W-1:0] axis_magnitude(input logic [MAG_W-1:0] raw);
    logic [MAG_W-1:0] mag;
    mag = raw[MAG_W-1] ? (~raw + MAG_W'(1)) : raw;
`ifdef AXIS_BCD_SCALE_EN
    return {mag, 2'b00};
`else
    return mag;
`endif
  endfunction

endpackage

// File: rtl/axis_bcd_scheduler_conv.sv
// Serial shift-add-3 binary to BCD converter (bcd_serial_conv).
// One magnitude bit is consumed per shift cycle, MSB first. A down-counter
// loaded with W-1 flags the final shift so the FSM knows when to leave SHIFT.
// Width follows CONV_W, which depends on AXIS_BCD_SCALE_EN.
module bcd_serial_conv
  import axis_bcd_pkg::*;
#(
  parameter int W = CONV_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [W-1:0]     mag,
  output logic [BCD_W-1:0] bcd,
  output logic             done
);

  localparam int CNT_W = $clog2(W);

  logic [W-1:0]     bin_q;
  logic [BCD_W-1:0] bcd_q;
  logic [BCD_W-1:0] bcd_adj;
  logic [CNT_W-1:0] cnt_q;

  // Digit correction applied to the current BCD accumulator before shifting.
  always_comb begin
    bcd_adj = bcd_add3(bcd_q);
  end

  // Shift register and remaining-bit counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      bin_q <= mag;
      bcd_q <= '0;
      cnt_q <= CNT_W'(W - 1);
    end else if (shift) begin
      {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
      if (cnt_q != '0) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  assign bcd  = bcd_q;
  assign done = shift && (cnt_q == '0);

endmodule

// File: rtl/axis_bcd_scheduler.sv
// Three-axis sign/BCD converter. Latches one X/Y/Z sample, converts the axes
// one after another through a single serial converter, and publishes all six
// results together with a one-cycle result_valid.
// Build option: AXIS_BCD_SCALE_EN selects the x4 (mg) magnitude, W=12.
//
// state | meaning
// IDLE  | ready=1, waiting for sample_valid
// LOAD  | load magnitude of the selected axis into the converter
// SHIFT | one magnitude bit per cycle, W cycles
// STORE | capture BCD and sign into the axis shadow, advance X->Y->Z
// DONE  | outputs updated, result_valid=1 for this cycle
module axis_bcd_scheduler
  import axis_bcd_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] x_data,
  input  logic [15:0] y_data,
  input  logic [15:0] z_data,
  input  logic        sample_valid,
  output logic        ready,
  output logic [15:0] bcd_x,
  output logic [15:0] bcd_y,
  output logic [15:0] bcd_z,
  output logic        neg_x,
  output logic        neg_y,
  output logic        neg_z,
  output logic        result_valid,
  output logic [7:0]  drop_cnt
);

  localparam logic [7:0] DROP_MAX = 8'hFF;

  state_t            state;
  axis_t             axis_sel;
  logic [MAG_W-1:0]  x_raw, y_raw, z_raw;
  logic [MAG_W-1:0]  axis_raw;
  logic [CONV_W-1:0] axis_mag;
  logic [BCD_W-1:0]  shadow_x, shadow_y, shadow_z;
  logic              shadow_nx, shadow_ny, shadow_nz;
  logic [BCD_W-1:0]  conv_bcd;
  logic              conv_done;
  logic              conv_load;
  logic              conv_shift;
  logic              unused_bits;

  // Bits [12:7] of each axis word carry no part of the 10-bit value.
  assign unused_bits = ^{x_data[12:7], y_data[12:7], z_data[12:7]};

  // Axis mux feeding the shared converter.
  always_comb begin
    axis_raw = x_raw;
    case (axis_sel)
      AXIS_X:  axis_raw = x_raw;
      AXIS_Y:  axis_raw = y_raw;
      AXIS_Z:  axis_raw = z_raw;
      default: axis_raw = x_raw;
    endcase
    axis_mag = axis_magnitude(axis_raw);
  end

  assign conv_load  = (state == LOAD);
  assign conv_shift = (state == SHIFT);

  bcd_serial_conv #(
    .W (CONV_W)
  ) u_conv (
    .clk   (clk),
    .reset (reset),
    .load  (conv_load),
    .shift (conv_shift),
    .mag   (axis_mag),
    .bcd   (conv_bcd),
    .done  (conv_done)
  );

  // Sequencer FSM with sample latch, shadow registers, outputs and drop counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      ready        <= 1'b1;
      result_valid <= 1'b0;
      axis_sel     <= AXIS_X;
      x_raw        <= '0;
      y_raw        <= '0;
      z_raw        <= '0;
      shadow_x     <= '0;
      shadow_y     <= '0;
      shadow_z     <= '0;
      shadow_nx    <= 1'b0;
      shadow_ny    <= 1'b0;
      shadow_nz    <= 1'b0;
      bcd_x        <= '0;
      bcd_y        <= '0;
      bcd_z        <= '0;
      neg_x        <= 1'b0;
      neg_y        <= 1'b0;
      neg_z        <= 1'b0;
      drop_cnt     <= '0;
    end else begin
      result_valid <= 1'b0;

      if (sample_valid && !ready && (drop_cnt != DROP_MAX)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end

      case (state)
        IDLE: begin
          if (sample_valid) begin
            x_raw    <= {x_data[6:0], x_data[15:13]};
            y_raw    <= {y_data[6:0], y_data[15:13]};
            z_raw    <= {z_data[6:0], z_data[15:13]};
            axis_sel <= AXIS_X;
            ready    <= 1'b0;
            state    <= LOAD;
          end
        end

        LOAD: begin
          state <= SHIFT;
        end

        SHIFT: begin
          if (conv_done) begin
            state <= STORE;
          end
        end

        STORE: begin
          case (axis_sel)
            AXIS_X: begin
              shadow_x  <= conv_bcd;
              shadow_nx <= axis_raw[MAG_W-1];
              axis_sel  <= AXIS_Y;
              state     <= LOAD;
            end
            AXIS_Y: begin
              shadow_y  <= conv_bcd;
              shadow_ny <= axis_raw[MAG_W-1];
              axis_sel  <= AXIS_Z;
              state     <= LOAD;
            end
            default: begin
              // Z result goes straight to the outputs so all six update on
              // entry to DONE, alongside result_valid.
              shadow_z     <= conv_bcd;
              shadow_nz    <= axis_raw[MAG_W-1];
              bcd_x        <= shadow_x;
              bcd_y        <= shadow_y;
              bcd_z        <= conv_bcd;
              neg_x        <= shadow_nx;
              neg_y        <= shadow_ny;
              neg_z        <= axis_raw[MAG_W-1];
              result_valid <= 1'b1;
              axis_sel     <= AXIS_X;
              state        <= DONE;
            end
          endcase
        end

        DONE: begin
          ready <= 1'b1;
          state <= IDLE;
        end

        default: begin
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_bcd_scheduler.sv
// Scoreboard bench for axis_bcd_scheduler. Expected results come from a
// decimal-division reference model pushed on accept and popped on result_valid;
// ready, result_valid and drop_cnt are tracked by a cycle model.
module tb_axis_bcd_scheduler;

`ifdef AXIS_BCD_SCALE_EN
  localparam int W = 12;
  localparam logic [15:0] X028 = 16'h0400, Y028 = 16'h0004, Z028 = 16'h2048, A029 = 16'h2044;
`else
  localparam int W = 10;
  localparam logic [15:0] X028 = 16'h0100, Y028 = 16'h0001, Z028 = 16'h0512, A029 = 16'h0511;
`endif
  localparam int LAT    = 3 * (W + 2) + 1;
  localparam int PERIOD = LAT + 1;
  localparam int ACC300 = (300 + PERIOD - 1) / PERIOD;

  logic        clk;
  logic        reset;
  logic [15:0] x_data, y_data, z_data;
  logic        sample_valid;
  logic        ready;
  logic [15:0] bcd_x, bcd_y, bcd_z;
  logic        neg_x, neg_y, neg_z;
  logic        result_valid;
  logic [7:0]  drop_cnt;
  logic [50:0] out_vec;

  axis_bcd_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .x_data       (x_data),
    .y_data       (y_data),
    .z_data       (z_data),
    .sample_valid (sample_valid),
    .ready        (ready),
    .bcd_x        (bcd_x),
    .bcd_y        (bcd_y),
    .bcd_z        (bcd_z),
    .neg_x        (neg_x),
    .neg_y        (neg_y),
    .neg_z        (neg_z),
    .result_valid (result_valid),
    .drop_cnt     (drop_cnt)
  );

  assign out_vec = {bcd_x, bcd_y, bcd_z, neg_x, neg_y, neg_z};

  typedef struct {
    logic [16:0] ex;
    logic [16:0] ey;
    logic [16:0] ez;
    int          acc;
  } sb_t;

  sb_t         sb_q[$];
  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          busy_left = 0;
  int          exp_drop = 0;
  int          rv_count = 0;
  int          last_rv = 0;
  int          prev_rv = 0;
  int          last_lat = 0;
  int          dut_acc = 0;
  logic [50:0] held = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference: {sign, 4-digit BCD magnitude} by decimal division.
  function automatic logic [16:0] model(input logic [15:0] d);
    logic [9:0] raw;
    int         mag;
    raw = {d[6:0], d[15:13]};
    mag = raw[9] ? (1024 - int'(raw)) : int'(raw);
`ifdef AXIS_BCD_SCALE_EN
    mag = mag * 4;
`endif
    return {raw[9], 4'(mag / 1000), 4'((mag / 100) % 10), 4'((mag / 10) % 10), 4'(mag % 10)};
  endfunction

  // Cycle model and scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset) begin
      sb_q.delete();
      busy_left = 0;
      exp_drop  = 0;
      held      = '0;
    end else begin
      if (sample_valid && ready) dut_acc++;
      check_val("ready", ready, busy_left == 0);
      check_val("result_valid", result_valid, busy_left == 1);
      check_val("drop_cnt", drop_cnt, exp_drop);
      if (result_valid) begin
        check_val("sb_nonempty", sb_q.size() != 0, 1);
        if (sb_q.size() != 0) begin
          sb_t e;
          e = sb_q.pop_front();
          check_val("bcd_x", bcd_x, e.ex[15:0]);
          check_val("neg_x", neg_x, e.ex[16]);
          check_val("bcd_y", bcd_y, e.ey[15:0]);
          check_val("neg_y", neg_y, e.ey[16]);
          check_val("bcd_z", bcd_z, e.ez[15:0]);
          check_val("neg_z", neg_z, e.ez[16]);
          last_lat = cyc - e.acc;
          check_val("latency", last_lat, LAT);
        end
        held     = out_vec;
        prev_rv  = last_rv;
        last_rv  = cyc;
        rv_count++;
      end else begin
        check_val("hold", out_vec, held);
      end
      if (sample_valid && busy_left == 0) begin
        sb_t n;
        n.ex  = model(x_data);
        n.ey  = model(y_data);
        n.ez  = model(z_data);
        n.acc = cyc;
        sb_q.push_back(n);
        busy_left = LAT;
      end else begin
        if (sample_valid && exp_drop != 255) exp_drop++;
        if (busy_left > 0) busy_left--;
      end
    end
  end

  task automatic send(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    x_data = x;
    y_data = y;
    z_data = z;
    sample_valid = 1'b1;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
  endtask

  task automatic wait_rv(input int target, input int bound);
    for (int k = 0; k < bound; k++) begin
      if (rv_count >= target) break;
      @(posedge clk);
      #1;
    end
    if (rv_count < target) check_val("rv_timeout", rv_count, target);
  endtask

  task automatic wait_ready(input int bound);
    for (int k = 0; k < bound; k++) begin
      if (ready === 1'b1) break;
      @(posedge clk);
      #1;
    end
    if (ready !== 1'b1) check_val("ready_timeout", ready, 1);
  endtask

  initial begin
    logic [15:0] edge_v [4];
    int          base;
    int          acc0;
    edge_v = '{16'h0000, 16'hE07F, 16'h0040, 16'h8000};
    reset = 1'b1;
    sample_valid = 1'b0;
    x_data = '0;
    y_data = '0;
    z_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_ready", ready, 1);
    check_val("rst_outs", out_vec, 0);
    check_val("rst_rv", result_valid, 0);
    check_val("rst_drop", drop_cnt, 0);
    reset = 1'b0;

    // Mixed-sign reference sample
    base = rv_count;
    send(16'h800C, 16'hE07F, 16'h0040);
    wait_rv(base + 1, 100);
    check_val("r028_bx", bcd_x, X028);
    check_val("r028_nx", neg_x, 0);
    check_val("r028_by", bcd_y, Y028);
    check_val("r028_ny", neg_y, 1);
    check_val("r028_bz", bcd_z, Z028);
    check_val("r028_nz", neg_z, 1);

    // Largest positive value on all axes, with latency
    base = rv_count;
    send(16'hE03F, 16'hE03F, 16'hE03F);
    wait_rv(base + 1, 100);
    check_val("r029_bx", bcd_x, A029);
    check_val("r029_bz", bcd_z, A029);
    check_val("r029_neg", {neg_x, neg_y, neg_z}, 0);
    check_val("r029_lat", last_lat, LAT);

    // Edge values and random words
    for (int i = 0; i < 8; i++) begin
      logic [15:0] a, b, c;
      a = (i < 4) ? edge_v[i] : 16'($urandom());
      b = 16'($urandom());
      c = (i < 4) ? edge_v[3 - i] : 16'($urandom());
      wait_ready(100);
      base = rv_count;
      send(a, b, c);
      wait_rv(base + 1, 100);
    end

    // Sample in DONE is dropped, the one in the next IDLE is accepted
    wait_ready(100);
    base = rv_count;
    send(16'h1234, 16'h5678, 16'h9ABC);
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      #1;
      if (result_valid) break;
    end
    check_val("done_seen", result_valid, 1);
    x_data = 16'h1111; y_data = 16'h2222; z_data = 16'h3333;
    sample_valid = 1'b1;
    @(posedge clk);
    #1;
    x_data = 16'hE07F; y_data = 16'h0040; z_data = 16'h800C;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    wait_rv(base + 2, 100);

    // Back-to-back: second sample presented as ready rises
    wait_ready(100);
    base = rv_count;
    send(16'h4321, 16'hE03F, 16'h0001);
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      #1;
      if (ready) break;
    end
    send(16'h0040, 16'hC0A5, 16'h7E12);
    wait_rv(base + 2, 200);
    check_val("b2b_spacing", last_rv - prev_rv, PERIOD);

    // Continuous sample_valid for 300 cycles from a fresh IDLE
    wait_ready(100);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    acc0 = dut_acc;
    sample_valid = 1'b1;
    for (int k = 0; k < 300; k++) begin
      x_data = 16'($urandom());
      y_data = 16'($urandom());
      z_data = 16'($urandom());
      @(posedge clk);
      #1;
    end
    sample_valid = 1'b0;
    check_val("r030_accepts", dut_acc - acc0, ACC300);
    wait_ready(100);
    check_val("r030_drop_sat", drop_cnt, 255);

    // Reset in the middle of a conversion, colliding with sample_valid
    send(16'hE03F, 16'h0040, 16'hE07F);
    repeat (14) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    sample_valid = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    sample_valid = 1'b0;
    check_val("r031_ready", ready, 1);
    check_val("r031_outs", out_vec, 0);
    check_val("r031_rv", result_valid, 0);
    check_val("r031_drop", drop_cnt, 0);
    base = rv_count;
    repeat (60) @(posedge clk);
    #1;
    check_val("r031_no_rv", rv_count, base);

    // Recovery after the aborted conversion
    wait_ready(10);
    send(16'h800C, 16'h800C, 16'h0040);
    wait_rv(base + 1, 100);
    check_val("sb_drain", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
